// File: rtl/clk_gen.sv
// Divides sys_clk by DIV into a 50% duty c0 and raises a sticky locked after LOCK_CYCLES.
// Latency: c0/locked/areset are registered (1 sys_clk edge); no backpressure, free-running.
module clk_gen #(
  parameter int DIV         = 2,
  parameter int LOCK_CYCLES = 16
) (
  input  logic sys_clk,
  input  logic sys_rst,
  output logic inclk0,
  output logic areset,
  output logic c0,
  output logic locked
);

  localparam int HALF = DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int LW   = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES + 1) : 1;

  localparam logic [CW-1:0] CNT_LAST  = CW'(HALF - 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

  if ((DIV < 2) || ((DIV % 2) != 0)) begin : g_bad_div
    $error("clk_gen: DIV must be an even integer >= 2");
  end
  if (LOCK_CYCLES < 1) begin : g_bad_lock
    $error("clk_gen: LOCK_CYCLES must be >= 1");
  end

  logic [CW-1:0] div_cnt;
  logic [LW-1:0] lock_cnt;

  assign inclk0 = sys_clk;

  always_ff @(posedge sys_clk) begin
    areset <= sys_rst;
    if (sys_rst) begin
      div_cnt  <= '0;
      c0       <= 1'b0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      if (div_cnt == CNT_LAST) begin
        div_cnt <= '0;
        c0      <= ~c0;
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
      // Counter freezes at LOCK_CYCLES once locked, so it never wraps.
      if (!locked) begin
        lock_cnt <= lock_cnt + LW'(1);
        if (lock_cnt == LOCK_LAST) locked <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clk_gen.sv
// Drives three clk_gen configurations from one clock/reset and compares against an edge-count model.
module tb_clk_gen;

  localparam int NI = 3;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic [NI-1:0] inclk0, areset, c0, locked;

  always #10 sys_clk = ~sys_clk;

  clk_gen dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .inclk0(inclk0[0]), .areset(areset[0]), .c0(c0[0]), .locked(locked[0])
  );
  clk_gen #(.DIV(4), .LOCK_CYCLES(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .inclk0(inclk0[1]), .areset(areset[1]), .c0(c0[1]), .locked(locked[1])
  );
  clk_gen #(.DIV(6), .LOCK_CYCLES(5)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .inclk0(inclk0[2]), .areset(areset[2]), .c0(c0[2]), .locked(locked[2])
  );

  int vectors    = 0;
  int miscompares = 0;

  int   n_since_rel [NI];
  int   rises_dut   [NI];
  int   rises_exp   [NI];
  logic prev_dut    [NI];
  logic prev_exp    [NI];
  bit   count_rises = 1'b0;

  function automatic int div_of(input int i);
    case (i)
      0:       return 2;
      1:       return 4;
      default: return 6;
    endcase
  endfunction

  function automatic int lock_of(input int i);
    case (i)
      0:       return 16;
      1:       return 1;
      default: return 5;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // c0 after n edges since release = parity of completed half-periods.
  task automatic step(input logic rst);
    logic exp_c0, exp_lock;
    @(negedge sys_clk);
    for (int i = 0; i < NI; i++) check($sformatf("inclk0_lo[%0d]", i), 32'(inclk0[i]), 32'd0);
    sys_rst = rst;
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      if (rst) n_since_rel[i] = 0;
      else     n_since_rel[i]++;
      exp_c0   = rst ? 1'b0 : (((n_since_rel[i] / (div_of(i) / 2)) % 2) == 1);
      exp_lock = !rst && (n_since_rel[i] >= lock_of(i));
      check($sformatf("c0[%0d]", i),     32'(c0[i]),     32'(exp_c0));
      check($sformatf("locked[%0d]", i), 32'(locked[i]), 32'(exp_lock));
      check($sformatf("areset[%0d]", i), 32'(areset[i]), 32'(rst));
      check($sformatf("inclk0_hi[%0d]", i), 32'(inclk0[i]), 32'd1);
      if (count_rises) begin
        if (c0[i] && !prev_dut[i]) rises_dut[i]++;
        if (exp_c0 && !prev_exp[i]) rises_exp[i]++;
      end
      prev_dut[i] = c0[i];
      prev_exp[i] = exp_c0;
    end
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      n_since_rel[i] = 0;
      rises_dut[i]   = 0;
      rises_exp[i]   = 0;
      prev_dut[i]    = 1'b0;
      prev_exp[i]    = 1'b0;
    end

    // Single-cycle reset, then run past lock watching first rise and lock edge.
    step(1'b1);
    for (int k = 0; k < 29; k++) step(1'b0);
    // Mid-operation reset pulse, then re-lock.
    step(1'b1);
    for (int k = 0; k < 30; k++) step(1'b0);
    // Long reset hold.
    for (int k = 0; k < 100; k++) step(1'b1);
    for (int k = 0; k < 20; k++) step(1'b0);

    // 1000 locked cycles: count c0 rising edges.
    for (int i = 0; i < NI; i++) begin
      prev_dut[i] = c0[i];
      rises_dut[i] = 0;
      rises_exp[i] = 0;
    end
    count_rises = 1'b1;
    for (int k = 0; k < 1000; k++) step(1'b0);
    count_rises = 1'b0;
    for (int i = 0; i < NI; i++)
      check($sformatf("c0_rises[%0d]", i), 32'(rises_dut[i]), 32'(rises_exp[i]));
    check("c0_rises_div2", 32'(rises_dut[0]), 32'd500);
    check("c0_rises_div4", 32'(rises_dut[1]), 32'd250);

    // Random reset pulses and holds.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 99) < 4) begin
        int len = $urandom_range(1, 6);
        for (int j = 0; j < len; j++) step(1'b1);
      end else begin
        step(1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
